// File: rtl/tta_add_scheduler.sv
// Round-robin sharing of one pipelined adder FU among N TTA issue lanes.
// Define TTA_SUB_EN to enable per-lane a-b selected by op_sub.
module tta_add_scheduler #(
  parameter int XLEN  = 32,
  parameter int N     = 4,
  parameter int LAT   = 2,
  parameter int LANEW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N*XLEN-1:0] op_a,
  input  logic [N*XLEN-1:0] op_b,
  input  logic [N*5-1:0]    op_dest,
  input  logic [N-1:0]      op_sub,
  output logic [N-1:0]      gnt,
  output logic              res_valid,
  output logic [XLEN-1:0]   res_data,
  output logic [4:0]        res_dest,
  output logic [LANEW-1:0]  res_lane,
  output logic              res_we,
  input  logic              drain_req,
  output logic              drain_ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LANEW-1:0] ptr;
  logic [LANEW-1:0] sel;
  logic [LANEW-1:0] ptr_nxt;
  logic             hit;
  logic             fire;
  logic [XLEN-1:0]  a_sel;
  logic [XLEN-1:0]  b_sel;
  logic [XLEN-1:0]  sum;
  logic [4:0]       dest_sel;

  logic [LAT-1:0]   v;
  logic [XLEN-1:0]  pd   [LAT];
  logic [4:0]       pdst [LAT];
  logic [LANEW-1:0] pln  [LAT];

  // first requester at or after ptr, wrapping
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && req[(int'(ptr) + i) % N]) begin
        hit = 1'b1;
        sel = LANEW'((int'(ptr) + i) % N);
      end
    end
  end

  assign ptr_nxt = (int'(sel) == N - 1) ? '0 : sel + 1'b1;
  assign fire    = rst_n && (state == RUN) && hit;
  assign gnt     = fire ? (N'(1) << sel) : '0;

  assign a_sel    = op_a[int'(sel)*XLEN +: XLEN];
  assign b_sel    = op_b[int'(sel)*XLEN +: XLEN];
  assign dest_sel = op_dest[int'(sel)*5 +: 5];

`ifdef TTA_SUB_EN
  assign sum = op_sub[sel] ? a_sel - b_sel : a_sel + b_sel;
`else
  logic unused_sub;
  assign unused_sub = ^op_sub;
  assign sum        = a_sel + b_sel;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= ptr_nxt;
    end
  end

  // valids shift freely; payload only moves with a valid so the tail holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < LAT; k++) begin
        pd[k]   <= '0;
        pdst[k] <= '0;
        pln[k]  <= '0;
      end
    end else begin
      v[0] <= fire;
      if (fire) begin
        pd[0]   <= sum;
        pdst[0] <= dest_sel;
        pln[0]  <= sel;
      end
      for (int k = 1; k < LAT; k++) begin
        v[k] <= v[k-1];
        if (v[k-1]) begin
          pd[k]   <= pd[k-1];
          pdst[k] <= pdst[k-1];
          pln[k]  <= pln[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (drain_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!drain_req) state_nxt = RUN;
        else if (!busy) state_nxt = DONE;
      end
      DONE: begin
        if (!drain_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign busy      = |v;
  assign res_valid = v[LAT-1];
  assign res_data  = pd[LAT-1];
  assign res_dest  = pdst[LAT-1];
  assign res_lane  = pln[LAT-1];
  assign res_we    = res_valid && (res_dest != 5'd0);
  assign drain_ack = (state == DONE);

endmodule

// File: tb/tb_tta_add_scheduler.sv
// Bench for tta_add_scheduler: vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_tta_add_scheduler;

  localparam int XLEN  = 32;
  localparam int N     = 4;
  localparam int LAT   = 2;
  localparam int LANEW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*XLEN-1:0] op_a;
  logic [N*XLEN-1:0] op_b;
  logic [N*5-1:0]    op_dest;
  logic [N-1:0]      op_sub;
  logic [N-1:0]      gnt;
  logic              res_valid;
  logic [XLEN-1:0]   res_data;
  logic [4:0]        res_dest;
  logic [LANEW-1:0]  res_lane;
  logic              res_we;
  logic              drain_req;
  logic              drain_ack;
  logic              busy;

  tta_add_scheduler #(
    .XLEN(XLEN), .N(N), .LAT(LAT), .LANEW(LANEW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .op_a(op_a), .op_b(op_b), .op_dest(op_dest),
    .op_sub(op_sub), .gnt(gnt),
    .res_valid(res_valid), .res_data(res_data),
    .res_dest(res_dest), .res_lane(res_lane),
    .res_we(res_we), .drain_req(drain_req),
    .drain_ack(drain_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [XLEN-1:0] la [N];
  logic [XLEN-1:0] lb [N];
  logic [4:0]      ld [N];
  logic            ls [N];
  logic [N-1:0]    lreq;

  typedef struct {
    logic [XLEN-1:0] d;
    logic [4:0]      dst;
    int              lane;
    int              due;
  } exp_t;

  exp_t q[$];
  int   mptr;
  int   last_g;

  typedef struct {
    int              lane;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      dest;
    logic            sub;
    logic [XLEN-1:0] exp;
    logic            we;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [XLEN-1:0] ref_res(
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic s
  );
    logic en;
`ifdef TTA_SUB_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return (en && s) ? a - b : a + b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      op_a[i*XLEN +: XLEN] = la[i];
      op_b[i*XLEN +: XLEN] = lb[i];
      op_dest[i*5 +: 5]    = ld[i];
      op_sub[i]            = ls[i];
    end
    req = lreq;
  endtask

  task automatic new_op(input int i);
    la[i] = ($urandom_range(0, 3) == 0) ? '1 : $urandom();
    lb[i] = ($urandom_range(0, 3) == 0) ? XLEN'(1) : $urandom();
    ld[i] = 5'($urandom_range(0, 31));
    ls[i] = 1'($urandom_range(0, 1));
  endtask

  // check outputs for this cycle, then predict this cycle's grant
  task automatic cycle_check(input bit run);
    exp_t e;
    int g;
    logic [N-1:0] eg;
    chk("busy", busy, q.size() > 0);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("res_valid", res_valid, 1);
      chk("res_data", res_data, e.d);
      chk("res_dest", res_dest, e.dst);
      chk("res_lane", res_lane, e.lane);
      chk("res_we", res_we, e.dst != 0);
    end else begin
      chk("res_valid_idle", res_valid, 0);
    end
    g = -1;
    if (run) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && lreq[(mptr + k) % N]) g = (mptr + k) % N;
      end
    end
    eg = (g < 0) ? '0 : N'(1) << g;
    chk("gnt", gnt, eg);
    last_g = g;
    if (g >= 0) begin
      e.d    = ref_res(la[g], lb[g], ls[g]);
      e.dst  = ld[g];
      e.lane = g;
      e.due  = cyc + LAT;
      q.push_back(e);
      mptr = (g + 1) % N;
    end
  endtask

  task automatic idle_cycles(input int n);
    lreq = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive();
      #1;
      cycle_check(1);
    end
  endtask

  initial begin
    int saved;
    bit ok;

    tbl[0] = '{2, 32'd5, 32'd7, 5'd3, 1'b0, 32'd12, 1'b1};
    tbl[1] = '{0, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b0, 32'd1, 1'b0};
`ifdef TTA_SUB_EN
    tbl[2] = '{1, 32'd3, 32'd5, 5'd9, 1'b1, 32'hFFFF_FFFE, 1'b1};
`else
    tbl[2] = '{1, 32'd3, 32'd5, 5'd9, 1'b1, 32'd8, 1'b1};
`endif
    tbl[3] = '{3, 32'h8000_0000, 32'h8000_0000, 5'd31, 1'b0,
               32'd0, 1'b1};
    tbl[4] = '{1, 32'h1234_5678, 32'h1111_1111, 5'd1, 1'b0,
               32'h2345_6789, 1'b1};

    rst_n     = 1'b0;
    drain_req = 1'b0;
    lreq      = '1;
    for (int i = 0; i < N; i++) begin
      la[i] = XLEN'(100 * (i + 1));
      lb[i] = XLEN'(i + 1);
      ld[i] = 5'(i + 4);
      ls[i] = 1'b0;
    end
    drive();
    mptr   = 0;
    last_g = -1;

    // reset with all lanes requesting
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drain_ack", drain_ack, 0);
    end

    // release: lane 0 first, then round robin for 8 cycles
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk("rr_gnt", gnt, N'(1) << (k % N));
      cycle_check(1);
    end
    idle_cycles(LAT + 1);

    // single-lane vectors
    foreach (tbl[j]) begin
      @(negedge clk);
      lreq = '0;
      lreq[tbl[j].lane] = 1'b1;
      la[tbl[j].lane] = tbl[j].a;
      lb[tbl[j].lane] = tbl[j].b;
      ld[tbl[j].lane] = tbl[j].dest;
      ls[tbl[j].lane] = tbl[j].sub;
      drive();
      #1;
      chk("vec_gnt", gnt, N'(1) << tbl[j].lane);
      mptr = (tbl[j].lane + 1) % N;
      @(negedge clk);
      lreq = '0;
      drive();
      repeat (LAT - 1) @(negedge clk);
      chk("vec_valid", res_valid, 1);
      chk("vec_data", res_data, tbl[j].exp);
      chk("vec_dest", res_dest, tbl[j].dest);
      chk("vec_lane", res_lane, tbl[j].lane);
      chk("vec_we", res_we, tbl[j].we);
      @(negedge clk);
      chk("vec_valid_drop", res_valid, 0);
      chk("vec_data_hold", res_data, tbl[j].exp);
    end

    // reset with an op in flight discards it
    @(negedge clk);
    lreq = '0;
    lreq[0] = 1'b1;
    drive();
    #1;
    cycle_check(1);
    @(negedge clk);
    rst_n = 1'b0;
    lreq  = '1;
    drive();
    #1;
    chk("rst_mid_gnt", gnt, 0);
    q.delete();
    mptr = 0;
    repeat (LAT + 1) begin
      @(negedge clk);
      chk("rst_mid_valid", res_valid, 0);
      chk("rst_mid_busy", busy, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lreq  = '0;
    drive();
    #1;
    cycle_check(1);

    // drain with three ops issued, last one on the drain edge
    @(negedge clk);
    lreq = '1;
    drive();
    #1;
    cycle_check(1);
    @(negedge clk);
    #1;
    cycle_check(1);
    @(negedge clk);
    drain_req = 1'b1;
    #1;
    cycle_check(1);
    saved = mptr;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (q.size() > 0) chk("drain_ack_early", drain_ack, 0);
      cycle_check(0);
      if (drain_ack) ok = 1'b1;
    end
    chk("drain_ack_seen", ok, 1);
    chk("drain_q_empty", q.size(), 0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("drain_ack_hold", drain_ack, 1);
      cycle_check(0);
    end
    @(negedge clk);
    drain_req = 1'b0;
    #1;
    cycle_check(0);
    @(negedge clk);
    #1;
    chk("resume_ack", drain_ack, 0);
    chk("resume_gnt", gnt, N'(1) << saved);
    cycle_check(1);
    idle_cycles(LAT + 1);

    // drain withdrawn while still draining
    @(negedge clk);
    lreq = '1;
    drain_req = 1'b1;
    drive();
    #1;
    cycle_check(1);
    @(negedge clk);
    drain_req = 1'b0;
    #1;
    cycle_check(0);
    @(negedge clk);
    #1;
    cycle_check(1);
    idle_cycles(LAT + 1);

    // random traffic
    lreq = '0;
    last_g = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!lreq[i] || i == last_g) begin
          lreq[i] = ($urandom_range(0, 2) != 0);
          if (lreq[i]) new_op(i);
        end else if ($urandom_range(0, 15) == 0) begin
          lreq[i] = 1'b0;
        end
      end
      drive();
      #1;
      cycle_check(1);
    end
    idle_cycles(LAT + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
